// File: rtl/updown_counter_n_if.sv
// rtl/updown_counter_n_if.sv - control/status bundle between a counter user and updown_counter_n
interface updown_counter_n_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up_dn;
    logic             one_shot;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             done;

    // The user of the counter drives controls and observes status.
    modport master (
        output en, up_dn, one_shot, load, load_val,
        input  count, tc, wrap, done
    );

    // The counter itself.
    modport slave (
        input  en, up_dn, one_shot, load, load_val,
        output count, tc, wrap, done
    );
endinterface

// File: rtl/updown_counter_n.sv
// rtl/updown_counter_n.sv - modulo up/down counter with load, one-shot and wrap pulse; optional prescaler under COUNTER_PRESCALER_EN
module updown_counter_n #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int INIT_VAL = 0,
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              reset,
    updown_counter_n_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] INIT = WIDTH'(INIT_VAL);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    // Reject parameter sets that would silently misbehave.
    if (WIDTH < 2 || MAX_VAL < 1 || MAX_VAL > 2**WIDTH-1 || INIT_VAL < 0 ||
        INIT_VAL > MAX_VAL || PRESCALE < 1) begin : g_bad_params
        $error("updown_counter_n: illegal parameter combination");
    end

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             done_q;
    logic             step;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (count_q == MAX);
    assign at_zero = (count_q == '0);

`ifdef COUNTER_PRESCALER_EN
    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

    logic [PS_W-1:0] ps_q;

    // A step is allowed only on the last enabled cycle of each prescale period.
    assign step = (ps_q == PS_LAST);

    // Prescaler advances on enabled, non-loading, not-finished cycles and restarts on load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q <= '0;
        end else if (bus.load) begin
            ps_q <= '0;
        end else if (!done_q && bus.en) begin
            ps_q <= step ? '0 : ps_q + PS_ONE;
        end
    end
`else
    assign step = 1'b1;
`endif

    // Counter state: reset > load > done-hold > enabled step > hold; wrap is a one-edge pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= INIT;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.load) begin
            count_q <= (bus.load_val > MAX) ? MAX : bus.load_val;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (done_q) begin
            wrap_q  <= 1'b0;
        end else if (bus.en && step) begin
            wrap_q <= 1'b0;
            if (bus.up_dn) begin
                if (!at_max) begin
                    count_q <= count_q + ONE;
                end else if (!bus.one_shot) begin
                    count_q <= '0;
                    wrap_q  <= 1'b1;
                end else begin
                    done_q  <= 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_q <= count_q - ONE;
                end else if (!bus.one_shot) begin
                    count_q <= MAX;
                    wrap_q  <= 1'b1;
                end else begin
                    done_q  <= 1'b1;
                end
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.done  = done_q;
    // Terminal flag tracks the live direction so a direction change is reflected at once.
    assign bus.tc    = (bus.up_dn & at_max) | (~bus.up_dn & at_zero);
endmodule

// File: tb/tb_updown_counter_n.sv
// tb/tb_updown_counter_n.sv - scoreboard bench for updown_counter_n (WIDTH=4, MAX_VAL=9, PRESCALE=3)
module tb_updown_counter_n;
    logic clk;
    logic reset;

    updown_counter_n_if #(.WIDTH(4)) bus ();

    updown_counter_n #(
        .WIDTH(4), .MAX_VAL(9), .INIT_VAL(0), .PRESCALE(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int         idx;
        logic [3:0] count;
        logic       tc;
        logic       wrap;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector at the falling edge and queue the state expected after the next rising edge.
    task automatic v(input bit rst, input bit ld, input logic [3:0] lv, input bit en,
                     input bit up, input bit os, input logic [3:0] c, input bit tc,
                     input bit wr, input bit dn, input bit async_chk = 1'b0);
        exp_t e;
        @(negedge clk);
        reset        = rst;
        bus.load     = ld;
        bus.load_val = lv;
        bus.en       = en;
        bus.up_dn    = up;
        bus.one_shot = os;
        vec_no++;
        e.idx = vec_no; e.count = c; e.tc = tc; e.wrap = wr; e.done = dn;
        exp_q.push_back(e);
        if (async_chk) begin
            #1;
            checks++;
            if (bus.count !== 4'd0 || bus.wrap !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL async_reset: count=%0d wrap=%b done=%b, required count=0 wrap=0 done=0",
                         bus.count, bus.wrap, bus.done);
            end
        end
    endtask

    // Monitor: after each rising edge compare the DUT outputs with the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.count !== e.count || bus.tc !== e.tc ||
                    bus.wrap !== e.wrap || bus.done !== e.done) begin
                    errors++;
                    $display("FAIL vec%0d: count=%0d tc=%b wrap=%b done=%b, required count=%0d tc=%b wrap=%b done=%b",
                             e.idx, bus.count, bus.tc, bus.wrap, bus.done,
                             e.count, e.tc, e.wrap, e.done);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus.load = 1'b0; bus.load_val = 4'd0; bus.en = 1'b0;
        bus.up_dn = 1'b1; bus.one_shot = 1'b0;
`ifndef COUNTER_PRESCALER_EN
        // reset state
        v(1,0,0,0,1,0, 0,0,0,0);
        // count up 1..9 then wrap to 0
        for (int i = 1; i <= 9; i++)
            v(0,0,0,1,1,0, 4'(i), (i == 9), 0, 0);
        v(0,0,0,1,1,0, 0,0,1,0);
        v(0,0,0,0,1,0, 0,0,0,0);
        // reset then count down: 0 -> 9 with wrap, then 8, 7; then reverse direction
        v(1,0,0,0,0,0, 0,1,0,0);
        v(0,0,0,1,0,0, 9,0,1,0);
        v(0,0,0,1,0,0, 8,0,0,0);
        v(0,0,0,1,0,0, 7,0,0,0);
        v(0,0,0,1,1,0, 8,0,0,0);
        // one-shot up from 7: 8, 9, then done and hold
        v(0,1,7,0,1,1, 7,0,0,0);
        v(0,0,0,1,1,1, 8,0,0,0);
        v(0,0,0,1,1,1, 9,1,0,0);
        v(0,0,0,1,1,1, 9,1,0,1);
        v(0,0,0,1,1,1, 9,1,0,1);
        v(0,0,0,1,1,1, 9,1,0,1);
        v(0,0,0,0,0,1, 9,0,0,1);
        v(0,0,0,1,0,1, 9,0,0,1);
        v(0,0,0,1,1,0, 9,1,0,1);
        v(0,1,3,1,1,1, 3,0,0,0);
        // load clipping and load-over-enable priority
        v(0,1,15,1,1,0, 9,1,0,0);
        v(0,1,4,1,1,0, 4,0,0,0);
        v(0,0,0,1,1,0, 5,0,0,0);
        // one-shot down to 0
        v(0,1,1,0,0,1, 1,0,0,0);
        v(0,0,0,1,0,1, 0,1,0,0);
        v(0,0,0,1,0,1, 0,1,0,1);
        // asynchronous reset mid-clock at count=6, then increment on first edge after release
        v(0,1,6,0,1,0, 6,0,0,0);
        v(1,0,0,1,1,0, 0,0,0,0, 1'b1);
        v(0,0,0,1,1,0, 1,0,0,0);
        v(0,0,0,1,1,0, 2,0,0,0);
`else
        // PRESCALE=3: a step every third enabled edge
        v(1,0,0,0,1,0, 0,0,0,0);
        v(0,0,0,1,1,0, 0,0,0,0);
        v(0,0,0,1,1,0, 0,0,0,0);
        v(0,0,0,1,1,0, 1,0,0,0);
        v(0,0,0,1,1,0, 1,0,0,0);
        // two disabled cycles delay the next step by two
        v(0,0,0,0,1,0, 1,0,0,0);
        v(0,0,0,0,1,0, 1,0,0,0);
        v(0,0,0,1,1,0, 1,0,0,0);
        v(0,0,0,1,1,0, 2,0,0,0);
        v(0,0,0,1,1,0, 2,0,0,0);
        // load mid-prescale restarts the spacing
        v(0,1,5,1,1,0, 5,0,0,0);
        v(0,0,0,1,1,0, 5,0,0,0);
        v(0,0,0,1,1,0, 5,0,0,0);
        v(0,0,0,1,1,0, 6,0,0,0);
`endif
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
